// File: rtl/dmem_sync_ctrl.sv
// dmem_sync_ctrl: clocked, byte-addressed, big-endian data memory with a
// request/response handshake and WAIT_STATES extra busy cycles per access.
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   -> misaligned halfword/word requests complete with rsp_err=1
//   undefined -> misaligned requests are force-aligned and complete normally
module dmem_sync_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACCESS,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    rw_q, rw_d;
    logic [1:0]              size_q, size_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [7:0]              mem_q [DEPTH];

    logic                    acc_err;
    logic [ADDR_WIDTH-1:0]   base;
    logic [ADDR_WIDTH-1:0]   a1, a2, a3;
    logic [31:0]             rd_data;
    logic                    wr_en;
    logic [3:0]              be;
    logic [7:0]              wb0, wb1, wb2, wb3;

    // Access decode: error detection, effective address, read mux, byte lanes
    always_comb begin
        base = addr_q;
`ifdef DMEM_ALIGN_CHECK_EN
        acc_err = (size_q == 2'b11)
               || ((size_q == SIZE_HALF) && addr_q[0])
               || ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
`else
        acc_err = (size_q == 2'b11);
        if (size_q == SIZE_HALF) begin
            base[0] = 1'b0;
        end else if (size_q == SIZE_WORD) begin
            base[1:0] = 2'b00;
        end
`endif
        a1 = base + ADDR_WIDTH'(1);
        a2 = base + ADDR_WIDTH'(2);
        a3 = base + ADDR_WIDTH'(3);

        rd_data = '0;
        case (size_q)
            SIZE_BYTE: rd_data = {24'h0, mem_q[base]};
            SIZE_HALF: rd_data = {16'h0, mem_q[base], mem_q[a1]};
            SIZE_WORD: rd_data = {mem_q[base], mem_q[a1], mem_q[a2], mem_q[a3]};
            default:   rd_data = '0;
        endcase

        // Lane 0 is always the byte at the (aligned) base address
        be  = 4'b0000;
        wb0 = '0;
        wb1 = '0;
        wb2 = '0;
        wb3 = '0;
        case (size_q)
            SIZE_BYTE: begin
                be  = 4'b0001;
                wb0 = wdata_q[7:0];
            end
            SIZE_HALF: begin
                be  = 4'b0011;
                wb0 = wdata_q[15:8];
                wb1 = wdata_q[7:0];
            end
            SIZE_WORD: begin
                be  = 4'b1111;
                wb0 = wdata_q[31:24];
                wb1 = wdata_q[23:16];
                wb2 = wdata_q[15:8];
                wb3 = wdata_q[7:0];
            end
            default: be = 4'b0000;
        endcase

        wr_en = (state_q == ACCESS) && !reset && rw_q && !acc_err;
    end

    // Next-state, request latch and response register logic
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        rw_d        = rw_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rw_d    = req_rw;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_STATES > 0) begin
                        state_d    = BUSY;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            BUSY: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                rsp_err_d   = acc_err;
                rsp_rdata_d = (acc_err || rw_q) ? '0 : rd_data;
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            rw_q        <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rw_q        <= rw_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory array write port (not reset; write suppressed while reset is high)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (be[0]) mem_q[base] <= wb0;
            if (be[1]) mem_q[a1]   <= wb1;
            if (be[2]) mem_q[a2]   <= wb2;
            if (be[3]) mem_q[a3]   <= wb3;
        end
    end

    // Outputs are gated by reset so they read zero from the first reset cycle,
    // before the registers have seen a reset edge.
    always_comb begin
        req_ready = !reset && (state_q == IDLE);
        rsp_valid = !reset && (state_q == RESP);
        rsp_rdata = reset ? '0 : rsp_rdata_q;
        rsp_err   = !reset && rsp_err_q;
    end

endmodule

// File: tb/tb_dmem_sync_ctrl.sv
// Self-checking bench for dmem_sync_ctrl: instance 0 uses WAIT_STATES=2,
// instance 1 uses WAIT_STATES=3 (reset-abandon scenario).
// Expectations depend on DMEM_ALIGN_CHECK_EN in the same way as the design.
module tb_dmem_sync_ctrl;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_rw    [2];
    logic [1:0]  req_size  [2];
    logic [7:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;
    int          last_accept [2];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_sync_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u_dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
        .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_sync_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
        .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int ws(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    // One complete transaction: wait for ready, drive, check latency, ready
    // low while busy, optional accept spacing, then scoreboard compare.
    // hold=1 leaves req_valid high with scrambled inputs while busy.
    task automatic xfer(input int d, input logic rw, input logic [1:0] size,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input bit hold, input bit check_gap, input string name);
        exp_t e;
        int   n;
        bit   ready_busy;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);

        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!req_ready[d]) begin
            n_fail++;
            $display("FAIL %s accept: req_ready never rose (got %b, want 1)", name, req_ready[d]);
            req_valid[d] = 1'b0;
            void'(sb.pop_back());
            return;
        end
        req_rw[d]    = rw;
        req_size[d]  = size;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        if (check_gap) begin
            if ((cyc - last_accept[d]) !== ws(d) + 3) begin
                n_fail++;
                $display("FAIL %s accept_gap: got %0d cycles, want %0d", name,
                         cyc - last_accept[d], ws(d) + 3);
            end
        end
        last_accept[d] = cyc;

        @(posedge clk);
        #1;
        if (hold) begin
            req_rw[d]    = 1'($urandom);
            req_size[d]  = 2'($urandom);
            req_addr[d]  = 8'($urandom);
            req_wdata[d] = $urandom;
        end else begin
            req_valid[d] = 1'b0;
        end

        n = 0;
        ready_busy = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!rsp_valid[d] && req_ready[d]) ready_busy = 1'b1;
        end while (!rsp_valid[d] && n < 60);

        n_checks++;
        if (n !== ws(d) + 2) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, n, ws(d) + 2);
        end
        n_checks++;
        if (ready_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_busy: req_ready seen %b while busy, want 0", name, ready_busy);
        end
        if (!rsp_valid[d]) begin
            void'(sb.pop_front());
            return;
        end

        e = sb.pop_front();
        n_checks++;
        if (rsp_rdata[d] !== e.rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %h, want %h", name, rsp_rdata[d], e.rdata);
        end
        n_checks++;
        if (rsp_err[d] !== e.err) begin
            n_fail++;
            $display("FAIL %s err: got %b, want %b", name, rsp_err[d], e.err);
        end
    endtask

    task automatic test_reset(input int d);
        reset[d]     = 1'b1;
        req_valid[d] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== 35'h0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got ready=%b valid=%b err=%b rdata=%h, want all 0",
                         d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
            end
        end
        @(posedge clk);
        #1 reset[d] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready dut%0d: got %b, want 1", d, req_ready[d]);
        end
    endtask

    task automatic test_word_write;
        xfer(0, 1'b1, SZ_W, 8'd0, 32'h11223344, 32'h0, 1'b0, 1'b0, 1'b0, "wr_word0");
    endtask

    task automatic test_byte_merge;
        xfer(0, 1'b1, SZ_B, 8'd0, 32'h123456A6, 32'h0, 1'b0, 1'b0, 1'b0, "wr_byte0");
        xfer(0, 1'b1, SZ_B, 8'd2, 32'hFFFFFFDD, 32'h0, 1'b0, 1'b0, 1'b0, "wr_byte2");
        xfer(0, 1'b0, SZ_W, 8'd0, 32'h0,        32'hA622DD44, 1'b0, 1'b0, 1'b0, "rd_word0");
        xfer(0, 1'b0, SZ_B, 8'd3, 32'h0,        32'h00000044, 1'b0, 1'b0, 1'b0, "rd_byte3");
        repeat (3) @(negedge clk);
        n_checks++;
        if (rsp_rdata[0] !== 32'h00000044) begin
            n_fail++;
            $display("FAIL rdata_hold: got %h, want %h", rsp_rdata[0], 32'h00000044);
        end
    endtask

    task automatic test_halfwords;
        xfer(0, 1'b1, SZ_H, 8'd4, 32'h9999ABCD, 32'h0, 1'b0, 1'b0, 1'b0, "wr_half4");
        xfer(0, 1'b1, SZ_H, 8'd6, 32'h0000EF01, 32'h0, 1'b0, 1'b0, 1'b0, "wr_half6");
        xfer(0, 1'b0, SZ_W, 8'd4, 32'h0,        32'hABCDEF01, 1'b0, 1'b0, 1'b0, "rd_word4");
        xfer(0, 1'b0, SZ_H, 8'd6, 32'h0,        32'h0000EF01, 1'b0, 1'b0, 1'b0, "rd_half6");
    endtask

    task automatic test_top_boundary;
        xfer(0, 1'b1, SZ_W, 8'd252, 32'h33445566, 32'h0, 1'b0, 1'b0, 1'b0, "wr_word252");
        xfer(0, 1'b0, SZ_W, 8'd252, 32'h0, 32'h33445566, 1'b0, 1'b0, 1'b0, "rd_word252");
        xfer(0, 1'b0, SZ_B, 8'd255, 32'h0, 32'h00000066, 1'b0, 1'b0, 1'b0, "rd_byte255");
        xfer(0, 1'b0, SZ_H, 8'd254, 32'h0, 32'h00005566, 1'b0, 1'b0, 1'b0, "rd_half254");
    endtask

    task automatic test_errors;
        xfer(0, 1'b1, SZ_W, 8'd12, 32'h55667788, 32'h0, 1'b0, 1'b0, 1'b0, "wr_word12");
        xfer(0, 1'b1, SZ_X, 8'd12, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, "wr_illegal");
        xfer(0, 1'b0, SZ_W, 8'd12, 32'h0, 32'h55667788, 1'b0, 1'b0, 1'b0, "rd_after_illegal");
        xfer(0, 1'b0, SZ_X, 8'd12, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "rd_illegal");
`ifdef DMEM_ALIGN_CHECK_EN
        xfer(0, 1'b1, SZ_W, 8'd13, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b0, "wr_misaligned");
        xfer(0, 1'b0, SZ_W, 8'd12, 32'h0, 32'h55667788, 1'b0, 1'b0, 1'b0, "rd_after_misaligned");
        xfer(0, 1'b0, SZ_H, 8'd5,  32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "rd_half_misaligned");
`else
        xfer(0, 1'b1, SZ_W, 8'd13, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0, "wr_misaligned");
        xfer(0, 1'b0, SZ_W, 8'd12, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, "rd_after_misaligned");
        xfer(0, 1'b0, SZ_H, 8'd5,  32'h0, 32'h0000ABCD, 1'b0, 1'b0, 1'b0, "rd_half_misaligned");
`endif
    endtask

    task automatic test_back_to_back;
        xfer(0, 1'b0, SZ_W, 8'd0,   32'h0, 32'hA622DD44, 1'b0, 1'b1, 1'b0, "b2b_0");
        xfer(0, 1'b0, SZ_W, 8'd4,   32'h0, 32'hABCDEF01, 1'b0, 1'b1, 1'b1, "b2b_1");
        xfer(0, 1'b0, SZ_B, 8'd255, 32'h0, 32'h00000066, 1'b0, 1'b0, 1'b1, "b2b_2");
    endtask

    task automatic test_reset_midop;
        bit seen;
        int n;
        test_reset(1);
        xfer(1, 1'b1, SZ_W, 8'd8, 32'h01020304, 32'h0, 1'b0, 1'b0, 1'b0, "mid_prior");
        n = 0;
        @(negedge clk);
        while (!req_ready[1] && n < 60) begin
            @(negedge clk);
            n++;
        end
        req_rw[1]    = 1'b1;
        req_size[1]  = SZ_W;
        req_addr[1]  = 8'd8;
        req_wdata[1] = 32'hCAFEF00D;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen = 1'b1;
            if (i == 1) reset[1] = 1'b1;
            if (i == 3) reset[1] = 1'b0;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_rsp: rsp_valid seen %b, want 0", seen);
        end
        xfer(1, 1'b0, SZ_W, 8'd8, 32'h0, 32'h01020304, 1'b0, 1'b0, 1'b0, "mid_readback");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i]       = 1'b1;
            req_valid[i]   = 1'b0;
            req_rw[i]      = 1'b0;
            req_size[i]    = '0;
            req_addr[i]    = '0;
            req_wdata[i]   = '0;
            last_accept[i] = 0;
        end
        test_reset(0);
        test_word_write;
        test_byte_merge;
        test_halfwords;
        test_top_boundary;
        test_errors;
        test_back_to_back;
        test_reset_midop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
